// File: rtl/police_sprite_fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// police_sprite_pkg : sprite geometry and shared types for the sprite fetch
// Revision: 1.0
// ---------------------------------------------------------------------------
package police_sprite_pkg;
  localparam int SPR_W    = 20;
  localparam int SPR_H    = 35;
  localparam int FRAMES   = 2;
  localparam int SPR_SIZE = SPR_W * SPR_H;
  localparam int ADDR_W   = 19;
  localparam int PIX_W    = 5;
  localparam int FSEL_W   = (FRAMES > 1) ? $clog2(FRAMES) : 1;

  typedef logic [9:0]        coord_t;
  typedef logic [10:0]       wcoord_t;
  typedef logic [ADDR_W-1:0] rom_addr_t;
  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [FSEL_W-1:0] fsel_t;
endpackage
`default_nettype wire

// File: rtl/police_sprite_fetch_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// police_sprite_fetch_if : beam/position inputs, ROM port and pixel outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
interface police_sprite_fetch_if;
  import police_sprite_pkg::*;

  logic      frame_tick;
  coord_t    DrawX;
  coord_t    DrawY;
  coord_t    PosX;
  coord_t    PosY;
  logic      facing_left;
  logic      moving;
  pix_t      rom_data;
  rom_addr_t rom_addr;
  pix_t      pixel_idx;
  logic      pixel_on;

  modport master (
    output frame_tick, DrawX, DrawY, PosX, PosY, facing_left, moving, rom_data,
    input  rom_addr, pixel_idx, pixel_on
  );

  modport slave (
    input  frame_tick, DrawX, DrawY, PosX, PosY, facing_left, moving, rom_data,
    output rom_addr, pixel_idx, pixel_on
  );
endinterface
`default_nettype wire

// File: rtl/police_sprite_fetch_anim_ctr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sprite_anim_ctr : frame-tick edge detect and walk-cycle frame selection
// Revision: 1.0
// ---------------------------------------------------------------------------
module sprite_anim_ctr
  import police_sprite_pkg::*;
#(
  parameter int ANIM_DIV = 8
) (
  input  wire   Clk,
  input  wire   Reset_n,
  input  wire   frame_tick_i,
  input  wire   moving_i,
  output fsel_t frame_sel_o
);
  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic             tick_q, tick_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fsel_t            sel_q, sel_d;
  logic             tick;

  always_comb begin
    tick_d = frame_tick_i;
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    tick   = frame_tick_i & ~tick_q;
    // moving only matters on a tick; dropping it snaps back to the idle pose
    if (tick) begin
      if (moving_i) begin
        if (cnt_q == CNT_W'(ANIM_DIV - 1)) begin
          cnt_d = '0;
          sel_d = (sel_q == FSEL_W'(FRAMES - 1)) ? '0 : sel_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
        sel_d = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tick_q <= 1'b0;
      cnt_q  <= '0;
      sel_q  <= '0;
    end else begin
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
    end
  end

  assign frame_sel_o = sel_q;
endmodule
`default_nettype wire

// File: rtl/police_sprite_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// police_sprite_fetch : beam-to-ROM address, 2-cycle pixel pipeline
// Revision: 1.0
// ---------------------------------------------------------------------------
module police_sprite_fetch
  import police_sprite_pkg::*;
#(
  parameter int ANIM_DIV   = 8,
  parameter int TRANSP_IDX = 0
) (
  input wire                   Clk,
  input wire                   Reset_n,
  police_sprite_fetch_if.slave bus
);
  fsel_t     frame_sel;
  wcoord_t   dx, dy, px, py, lx, ly, lx_eff;
  logic      hit;
  rom_addr_t rom_addr_q, rom_addr_d;
  logic      hit1_q, hit1_d;
  logic      hit2_q, hit2_d;

  sprite_anim_ctr #(.ANIM_DIV(ANIM_DIV)) u_anim (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick_i (bus.frame_tick),
    .moving_i     (bus.moving),
    .frame_sel_o  (frame_sel)
  );

  // 11-bit operands so PosX+SPR_W / PosY+SPR_H cannot wrap
  always_comb begin
    dx     = {1'b0, bus.DrawX};
    dy     = {1'b0, bus.DrawY};
    px     = {1'b0, bus.PosX};
    py     = {1'b0, bus.PosY};
    hit    = (dx >= px) && (dx < px + wcoord_t'(SPR_W)) &&
             (dy >= py) && (dy < py + wcoord_t'(SPR_H));
    lx     = dx - px;
    ly     = dy - py;
    lx_eff = bus.facing_left ? (wcoord_t'(SPR_W - 1) - lx) : lx;
    rom_addr_d = '0;
    if (hit) begin
      rom_addr_d = rom_addr_t'(frame_sel) * rom_addr_t'(SPR_SIZE)
                 + rom_addr_t'(ly) * rom_addr_t'(SPR_W)
                 + rom_addr_t'(lx_eff);
    end
    hit1_d = hit;
    hit2_d = hit1_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q <= '0;
      hit1_q     <= 1'b0;
      hit2_q     <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit1_q     <= hit1_d;
      hit2_q     <= hit2_d;
    end
  end

  assign bus.rom_addr  = rom_addr_q;
  assign bus.pixel_idx = hit2_q ? bus.rom_data : '0;
  assign bus.pixel_on  = hit2_q && (bus.rom_data != PIX_W'(TRANSP_IDX));
endmodule
`default_nettype wire

// File: tb/tb_police_sprite_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_police_sprite_fetch : random + directed check against a pixel-level model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_police_sprite_fetch;
  localparam int W = 20, H = 35, NFR = 2, DIV = 8, ROM_N = 1400;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [4:0] mem [ROM_N];

  police_sprite_fetch_if bus ();

  police_sprite_fetch #(.ANIM_DIV(DIV), .TRANSP_IDX(0)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ROM with a registered read
  initial begin
    forever begin
      @(posedge clk);
      bus.rom_data <= (int'(bus.rom_addr) < ROM_N) ? mem[bus.rom_addr] : 5'h1f;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what each output must be after every clock edge
  int exp_addr = 0, exp_idx = 0, exp_on = 0;
  int p_hit = 0, p_addr = 0, m_ticks = 0;
  bit m_prev = 0;

  initial begin
    int frame, lx, ly, a, h, x, y, px, py;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_addr = 0; exp_idx = 0; exp_on = 0;
        p_hit = 0; p_addr = 0; m_ticks = 0; m_prev = 0;
      end else begin
        frame = (m_ticks / DIV) % NFR;
        x = int'(bus.DrawX); y = int'(bus.DrawY);
        px = int'(bus.PosX); py = int'(bus.PosY);
        h = (x >= px && x < px + W && y >= py && y < py + H) ? 1 : 0;
        lx = x - px; ly = y - py;
        if (bus.facing_left) lx = W - 1 - lx;
        a = h ? frame * W * H + ly * W + lx : 0;
        exp_idx = p_hit ? int'(mem[p_addr]) : 0;
        exp_on  = (p_hit != 0 && mem[p_addr] != 0) ? 1 : 0;
        p_hit = h; p_addr = a; exp_addr = a;
        if (bus.frame_tick && !m_prev) m_ticks = bus.moving ? m_ticks + 1 : 0;
        m_prev = bus.frame_tick;
      end
    end
  end

  initial begin
    #2;
    forever begin
      @(negedge clk);
      chk("rom_addr", int'(bus.rom_addr), exp_addr);
      chk("pixel_idx", int'(bus.pixel_idx), exp_idx);
      chk("pixel_on", int'(bus.pixel_on), exp_on);
    end
  end

  task automatic cyc(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    cyc(0, 0);
    bus.frame_tick = 1'b0;
    cyc(0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int x, px;
    for (int i = 0; i < ROM_N; i++)
      mem[i] = (i % 16 == 3) ? 5'd0 : 5'($urandom_range(1, 31));
    mem[45] = 5'd7;
    mem[1]  = 5'd0;
    bus.frame_tick = 1'b0; bus.DrawX = '0; bus.DrawY = '0;
    bus.PosX = 10'd100; bus.PosY = 10'd50;
    bus.facing_left = 1'b0; bus.moving = 1'b0; bus.rom_data = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);

    // reset holds everything at zero even with in-box coordinates
    for (int i = 0; i < 4; i++) begin
      cyc(100 + i, 52);
      chk("rst_addr", int'(bus.rom_addr), 0);
      chk("rst_on", int'(bus.pixel_on), 0);
    end
    rst_n = 1'b1;
    cyc(0, 0); cyc(0, 0);

    cyc(105, 52);
    chk("lit_addr45", int'(bus.rom_addr), 45);
    cyc(0, 0);
    chk("lit_idx7", int'(bus.pixel_idx), 7);
    chk("lit_on1", int'(bus.pixel_on), 1);

    bus.facing_left = 1'b1;
    cyc(105, 52); chk("lit_flip54", int'(bus.rom_addr), 54);
    cyc(119, 52); chk("lit_flip40", int'(bus.rom_addr), 40);
    cyc(120, 52); chk("lit_miss0", int'(bus.rom_addr), 0);
    cyc(0, 0);    chk("lit_miss_on", int'(bus.pixel_on), 0);

    bus.facing_left = 1'b0;
    cyc(101, 50); cyc(0, 0);
    chk("lit_transp_idx", int'(bus.pixel_idx), 0);
    chk("lit_transp_on", int'(bus.pixel_on), 0);

    bus.moving = 1'b1;
    ticks(8);     cyc(100, 50); chk("lit_frame1", int'(bus.rom_addr), 700);
    ticks(8);     cyc(100, 50); chk("lit_frame0", int'(bus.rom_addr), 0);
    ticks(3);
    bus.moving = 1'b0; tick(); bus.moving = 1'b1;
    ticks(7);     cyc(100, 50); chk("lit_cnt_clr", int'(bus.rom_addr), 0);
    tick();       cyc(100, 50); chk("lit_after_clr", int'(bus.rom_addr), 700);
    ticks(7);
    bus.moving = 1'b0; tick();
    cyc(100, 50); chk("lit_drop_wrap", int'(bus.rom_addr), 0);

    bus.PosX = 10'd630; bus.PosY = 10'd50;
    cyc(639, 50); chk("lit_right9", int'(bus.rom_addr), 9);
    bus.PosY = 10'd470;
    cyc(630, 479); chk("lit_bottom180", int'(bus.rom_addr), 180);
    bus.PosX = 10'd640;
    for (int i = 0; i < 4; i++) begin
      cyc(600 + i * 13, 475);
      chk("lit_offscreen", int'(bus.rom_addr), 0);
    end

    for (int n = 0; n < 1500; n++) begin
      px = int'($urandom_range(0, 700));
      x  = px + int'($urandom_range(0, 30)) - 5;
      if (x < 0) x = 0;
      if (x > 639) x = 639;
      bus.PosX = 10'(px);
      bus.PosY = 10'($urandom_range(0, 500));
      bus.facing_left = 1'($urandom_range(0, 1));
      bus.moving = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) bus.frame_tick = ~bus.frame_tick;
      if (n == 700) begin
        #2 rst_n = 1'b0;
        cyc(x, int'(bus.PosY) + 3);
        cyc(x, int'(bus.PosY) + 3);
        rst_n = 1'b1;
      end
      cyc(x, int'(bus.PosY) + int'($urandom_range(0, 40)) - 3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
